// File: rtl/spi_pkg.sv
// Shared types and default timing for the SPI mode-0 byte master.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      BIT_LO,
      BIT_HI,
      GAP,
      HOLD
   } state_t;

   // {CPOL, CPHA}
   localparam logic [1:0] SPI_MODE0 = 2'b00;

   localparam int CLK_DIV_DEF  = 5;
   localparam int CS_SETUP_DEF = 5;
   localparam int CS_HOLD_DEF  = 5;
   localparam int GAP_MIN_DEF  = 10;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Phase timer for the SPI master: counts clk cycles in the current phase and
// flags the last cycle of the phase and the first cycle of the SCK-high phase.
module spi_sck_gen #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             hi_phase,
   input  logic [CNT_W-1:0] term,
   output logic             phase_end,
   output logic             rise
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (clear || phase_end) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + ONE;
      end
   end

   assign phase_end = (cnt_reg == term);
   assign rise      = hi_phase && (cnt_reg == '0);

endmodule

// File: rtl/spi_master_byte.sv
// SPI mode-0 byte master with a valid/ready command port and framed chip select.
// Define SPI_MASTER_LOOPBACK_EN to feed the MISO sampler from internal MOSI.
module spi_master_byte
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = CLK_DIV_DEF,
   parameter int CS_SETUP = CS_SETUP_DEF,
   parameter int CS_HOLD  = CS_HOLD_DEF,
   parameter int GAP_MIN  = GAP_MIN_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       frame_done,
   output logic       busy,
   output logic       spi_cs,
   output logic       spi_sck,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   localparam int MAX_T = max_of(max_of(CLK_DIV, CS_SETUP), max_of(CS_HOLD, GAP_MIN));
   localparam int CNT_W = $clog2(MAX_T);

   localparam logic [CNT_W-1:0] T_DIV   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] T_SETUP = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] T_HOLD  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] T_GAP   = CNT_W'(GAP_MIN - 1);

   state_t     state_reg, state_next;
   logic [7:0] tx_sh_reg, tx_sh_next;
   logic [7:0] rx_sh_reg, rx_sh_next;
   logic [7:0] rx_data_reg, rx_data_next;
   logic [2:0] bit_reg, bit_next;
   logic       last_reg, last_next;
   logic       gap_done_reg, gap_done_next;
   logic       rx_valid_reg, rx_valid_next;
   logic       frame_done_reg, frame_done_next;
   logic       ready_en_reg;

   logic [CNT_W-1:0] term;
   logic             phase_end;
   logic             sck_rise;
   logic             accept;
   logic             miso_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = spi_miso;
   assign miso_bit    = spi_mosi;
`else
   assign miso_bit = spi_miso;
`endif

   always_comb begin
      term = '0;
      case (state_reg)
         SETUP:          term = T_SETUP;
         BIT_LO, BIT_HI: term = T_DIV;
         GAP:            term = T_GAP;
         HOLD:           term = T_HOLD;
         default:        term = '0;
      endcase
   end

   spi_sck_gen #(
      .CNT_W(CNT_W)
   ) u_sck_gen (
      .clk      (clk),
      .rst      (rst),
      .clear    (state_next != state_reg),
      .hi_phase (state_reg == BIT_HI),
      .term     (term),
      .phase_end(phase_end),
      .rise     (sck_rise)
   );

   // ready_en keeps tx_ready low while rst is held and for the first cycle after.
   assign tx_ready   = ready_en_reg &&
                       ((state_reg == IDLE) || ((state_reg == GAP) && gap_done_reg));
   assign accept     = tx_valid && tx_ready;
   assign spi_cs     = (state_reg == IDLE);
   assign busy       = !spi_cs;
   assign spi_sck    = (state_reg == BIT_HI) ^ SPI_MODE0[1];
   assign spi_mosi   = (state_reg == IDLE) ? 1'b0 : tx_sh_reg[7];
   assign rx_valid   = rx_valid_reg;
   assign rx_data    = rx_data_reg;
   assign frame_done = frame_done_reg;

   always_comb begin
      state_next      = state_reg;
      tx_sh_next      = tx_sh_reg;
      rx_sh_next      = rx_sh_reg;
      rx_data_next    = rx_data_reg;
      bit_next        = bit_reg;
      last_next       = last_reg;
      gap_done_next   = gap_done_reg;
      rx_valid_next   = 1'b0;
      frame_done_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               tx_sh_next = tx_data;
               last_next  = tx_last;
               state_next = SETUP;
            end
         end
         SETUP: begin
            if (phase_end) begin
               bit_next   = 3'd7;
               state_next = BIT_LO;
            end
         end
         BIT_LO: begin
            if (phase_end) state_next = BIT_HI;
         end
         BIT_HI: begin
            if (sck_rise) rx_sh_next = {rx_sh_reg[6:0], miso_bit};
            if (phase_end) begin
               if (bit_reg == 3'd0) begin
                  rx_valid_next = 1'b1;
                  rx_data_next  = rx_sh_reg;
                  gap_done_next = 1'b0;
                  state_next    = last_reg ? HOLD : GAP;
               end else begin
                  bit_next   = bit_reg - 3'd1;
                  tx_sh_next = {tx_sh_reg[6:0], 1'b0};
                  state_next = BIT_LO;
               end
            end
         end
         GAP: begin
            // The timer keeps wrapping while waiting; gap_done latches the first expiry.
            if (phase_end) gap_done_next = 1'b1;
            if (accept) begin
               tx_sh_next = tx_data;
               last_next  = tx_last;
               bit_next   = 3'd7;
               state_next = BIT_LO;
            end
         end
         HOLD: begin
            if (phase_end) begin
               frame_done_next = 1'b1;
               state_next      = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_sh_reg      <= '0;
         rx_sh_reg      <= '0;
         rx_data_reg    <= '0;
         bit_reg        <= '0;
         last_reg       <= 1'b0;
         gap_done_reg   <= 1'b0;
         rx_valid_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
         ready_en_reg   <= 1'b0;
      end else begin
         tx_sh_reg      <= tx_sh_next;
         rx_sh_reg      <= rx_sh_next;
         rx_data_reg    <= rx_data_next;
         bit_reg        <= bit_next;
         last_reg       <= last_next;
         gap_done_reg   <= gap_done_next;
         rx_valid_reg   <= rx_valid_next;
         frame_done_reg <= frame_done_next;
         ready_en_reg   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte: a mode-0 slave model drives MISO, and a
// scoreboard compares received bytes and MOSI-captured bytes against queued expectations.
module tb_spi_master_byte;

   localparam int CLK_DIV = 5;
   localparam int CS_HOLD = 5;
   localparam int GAP_MIN = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0, tx_last = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, rx_valid, frame_done, busy, spi_cs, spi_sck, spi_mosi, spi_miso;
   logic [7:0] rx_data;

   logic       tx_valid2 = 1'b0, tx_last2 = 1'b0;
   logic [7:0] tx_data2 = 8'h00;
   logic       tx_ready2, rx_valid2, frame_done2, busy2, spi_cs2, spi_sck2, spi_mosi2;
   logic       spi_miso2 = 1'b0;
   logic [7:0] rx_data2;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] tx_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   spi_master_byte dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data), .frame_done(frame_done),
      .busy(busy), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   spi_master_byte #(.CLK_DIV(2)) dut2 (
      .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_data(tx_data2),
      .tx_last(tx_last2), .rx_valid(rx_valid2), .rx_data(rx_data2), .frame_done(frame_done2),
      .busy(busy2), .spi_cs(spi_cs2), .spi_sck(spi_sck2), .spi_mosi(spi_mosi2),
      .spi_miso(spi_miso2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Mode-0 slave model: presents miso_byte MSB first, advancing after each SCK fall.
   logic [7:0] miso_byte = 8'h00;
   logic [2:0] miso_idx = 3'd0;
   logic       miso_sck_d = 1'b0;
   always @(negedge clk) begin
      if (spi_cs) miso_idx <= 3'd0;
      else if (miso_sck_d && !spi_sck) miso_idx <= miso_idx + 3'd1;
      miso_sck_d <= spi_sck;
   end
   assign spi_miso = miso_byte[3'd7 - miso_idx];

   int         hi_run = 0, last_rise_cyc = 0, last_fall_cyc = 0, last_rxv_cyc = 0;
   int         rise_in_byte = 0, rxv_cnt = 0, fd_cnt = 0, cs_rise_cnt = 0;
   logic       sck_prev = 1'b0, cs_prev = 1'b1;
   logic [7:0] mosi_cap = 8'h00;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            sck_prev = 1'b0; cs_prev = 1'b1; hi_run = 0; rise_in_byte = 0;
         end else begin
            if (spi_sck && !sck_prev) begin
               if (rise_in_byte != 0) chk("sck_period", cyc - last_rise_cyc, 2 * CLK_DIV);
               last_rise_cyc = cyc;
               mosi_cap = {mosi_cap[6:0], spi_mosi};
               rise_in_byte++;
               if (rise_in_byte == 8) begin
                  rise_in_byte = 0;
                  if (tx_q.size() == 0) chk("mosi_unexpected", tx_q.size(), 1);
                  else chk("mosi_byte", mosi_cap, tx_q.pop_front());
               end
            end
            if (spi_sck) hi_run++;
            if (!spi_sck && sck_prev) begin
               chk("sck_high", hi_run, CLK_DIV);
               hi_run = 0;
               last_fall_cyc = cyc;
            end
            if (spi_sck && tx_valid) chk("ready_in_bit_hi", tx_ready, 0);
            if (rx_valid) begin
               rxv_cnt++;
               last_rxv_cyc = cyc;
               if (exp_q.size() == 0) chk("rx_unexpected", exp_q.size(), 1);
               else chk("rx_data", rx_data, exp_q.pop_front());
            end
            if (frame_done) begin
               fd_cnt++;
               chk("fd_after_fall", cyc - last_fall_cyc, CS_HOLD);
               chk("fd_cs_high", spi_cs, 1);
            end
            if (spi_cs && !cs_prev) cs_rise_cnt++;
            sck_prev = spi_sck;
            cs_prev  = spi_cs;
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic last, input logic [7:0] resp,
                       output int acc_cyc);
      bit ok = 0;
      @(negedge clk);
      tx_data = d; tx_last = last; tx_valid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (tx_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      acc_cyc = cyc;
      if (!ok) begin
         chk("accept_timeout", {31'd0, ok}, 1);
         tx_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         tx_valid = 1'b0;
         tx_data  = 8'h00;
         miso_byte = resp;
`ifdef SPI_MASTER_LOOPBACK_EN
         exp_q.push_back(d);
`else
         exp_q.push_back(resp);
`endif
         tx_q.push_back(d);
         $display("[TB] t=%0t sent tx=%02h last=%0b miso=%02h at cycle %0d", $time, d, last, resp, acc_cyc);
      end
   endtask

   task automatic wait_frame();
      int f0 = fd_cnt;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (fd_cnt != f0) return;
      end
      chk("frame_timeout", fd_cnt, f0 + 1);
   endtask

   initial begin
      int acc, rx0, fd0, cr0, r1, r2, rv;
      logic s2p;
      logic [7:0] rxd2;
      bit ok;

      repeat (3) @(negedge clk);
      chk("rst_cs", spi_cs, 1);
      chk("rst_sck", spi_sck, 0);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_ready", tx_ready, 1);

      // Single byte, one frame.
      send(8'hA5, 1'b1, 8'h3C, acc);
      chk("cs_low_after_accept", spi_cs, 0);
      chk("busy_after_accept", busy, 1);
      wait_frame();
      chk("single_sb_empty", exp_q.size(), 0);

      // Three-byte frame with tx_valid held across the preceding byte.
      rx0 = rxv_cnt; fd0 = fd_cnt; cr0 = cs_rise_cnt;
      send(8'h01, 1'b0, 8'h11, acc);
      send(8'h04, 1'b0, 8'h22, acc);
      chk("gap_accept_byte2", acc - last_rxv_cyc, GAP_MIN);
      send(8'h00, 1'b1, 8'h33, acc);
      chk("gap_accept_byte3", acc - last_rxv_cyc, GAP_MIN);
      wait_frame();
      chk("frame_rx_count", rxv_cnt - rx0, 3);
      chk("frame_fd_count", fd_cnt - fd0, 1);
      chk("frame_cs_rises", cs_rise_cnt - cr0, 1);

      // MISO held at 0: in loopback builds the echo of tx is expected instead.
      send(8'h5A, 1'b1, 8'h00, acc);
      wait_frame();

      // Reset in the middle of bit 4.
      send(8'hFF, 1'b1, 8'h96, acc);
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (rise_in_byte == 4) begin ok = 1; break; end
      end
      chk("reach_bit4", {31'd0, ok}, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_cs", spi_cs, 1);
      chk("arst_sck", spi_sck, 0);
      chk("arst_mosi", spi_mosi, 0);
      chk("arst_busy", busy, 0);
      chk("arst_tx_ready", tx_ready, 0);
      chk("arst_rx_data", rx_data, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      tx_q.delete();
      rx0 = rxv_cnt; fd0 = fd_cnt;
      repeat (200) @(negedge clk);
      chk("abort_no_rx_valid", rxv_cnt, rx0);
      chk("abort_no_frame_done", fd_cnt, fd0);
      send(8'h81, 1'b1, 8'h42, acc);
      wait_frame();
      chk("after_rst_rx_count", rxv_cnt - rx0, 1);

      // CLK_DIV=2 instance with MISO tied low.
      @(negedge clk);
      tx_data2 = 8'h80; tx_last2 = 1'b1; tx_valid2 = 1'b1;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (tx_ready2) begin ok = 1; break; end
         @(negedge clk);
      end
      chk("div2_accept", {31'd0, ok}, 1);
      @(posedge clk);
      #1 tx_valid2 = 1'b0;
      r1 = -1; r2 = -1; rv = -1; s2p = 1'b0; rxd2 = 8'h00;
      for (int i = 0; i < 300 && rv < 0; i++) begin
         @(negedge clk);
         if (spi_sck2 && !s2p) begin
            if (r1 < 0) r1 = cyc;
            else if (r2 < 0) r2 = cyc;
         end
         s2p = spi_sck2;
         if (rx_valid2) begin rv = cyc; rxd2 = rx_data2; end
      end
      chk("div2_sck_period", r2 - r1, 4);
      chk("div2_byte_time", rv - (r1 - 2), 32);
`ifdef SPI_MASTER_LOOPBACK_EN
      chk("div2_rx_data", rxd2, 8'h80);
`else
      chk("div2_rx_data", rxd2, 8'h00);
`endif
      $display("[TB] t=%0t div2 byte 80: rise1=%0d rise2=%0d rx_valid=%0d rx=%02h", $time, r1, r2, rv, rxd2);

      repeat (30) @(negedge clk);
      chk("final_rx_queue_empty", exp_q.size(), 0);
      chk("final_tx_queue_empty", tx_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: observed time %0t required finish earlier", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/spi_master_byte.md
Name: spi_master_byte

Overview:
- SPI mode-0 master that drives the `spi_slave` chip-select, clock and MOSI lines and captures MISO.
- It is the stage directly upstream of `spi_slave` and replaces hand-driven master stimulus with synthesizable RTL.
- Byte-oriented valid/ready command interface: each byte is sent MSB-first, and the byte received on MISO is returned.
- A `tx_last` flag closes the chip-select frame, so multi-byte frames (e.g. 0x01, 0x04, 0x00) share one CS assertion.

Parameters:
- CLK_DIV, 5, SCK half-period in clk cycles (minimum 2); SCK period = 2*CLK_DIV.
- CS_SETUP, 5, clk cycles from CS falling to the first SCK low phase start (minimum 1).
- CS_HOLD, 5, clk cycles from the end of the last bit to CS rising (minimum 1).
- GAP_MIN, 10, minimum clk cycles between bytes inside one frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- tx_valid  in  1  byte request valid
- tx_ready  out  1  block can accept a byte this cycle
- tx_data  in  8  byte to transmit, MSB first
- tx_last  in  1  deassert CS after this byte; sampled with tx_data
- rx_valid  out  1  one-cycle pulse; rx_data valid
- rx_data  out  8  byte captured from MISO
- frame_done  out  1  one-cycle pulse when CS returns high
- busy  out  1  high whenever spi_cs is low
- spi_cs  out  1  chip select, active low
- spi_sck  out  1  serial clock, idles low (CPOL=0)
- spi_mosi  out  1  master out
- spi_miso  in  1  master in

Behaviour:
- Interface decided: single clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: spi_cs=1, spi_sck=0, spi_mosi=0, tx_ready=0, rx_valid=0, rx_data=0, frame_done=0, busy=0. The FSM returns to IDLE.
- Reset asserted mid-byte aborts immediately. No rx_valid or frame_done is produced.
- FSM states: IDLE, SETUP, BIT_LO, BIT_HI, GAP, HOLD.
- IDLE:
  - tx_ready=1.
  - On tx_valid&&tx_ready, latch tx_data and tx_last; next cycle spi_cs=0 and go to SETUP.
- SETUP: count CS_SETUP cycles, then go to BIT_LO with bit index 7.
- BIT_LO:
  - spi_sck=0; spi_mosi=shift[7] is driven from the first cycle of the phase.
  - Lasts CLK_DIV cycles, then go to BIT_HI.
- BIT_HI:
  - spi_sck=1 for CLK_DIV cycles.
  - spi_miso is sampled into the rx shift register on the first cycle of BIT_HI (rising edge). Mode 0.
  - At the end, if the bit index is 0: spi_sck=0, rx_valid pulses for 1 cycle with rx_data = the captured byte.
    - Go to HOLD if tx_last was latched; otherwise go to GAP.
  - If the bit index is not 0: decrement it, shift tx, and go to BIT_LO.
- Byte time from the first BIT_LO cycle to the rx_valid cycle is 16*CLK_DIV cycles.
- GAP:
  - spi_cs stays 0 and spi_sck stays 0.
  - tx_ready=1 only after GAP_MIN cycles have elapsed.
  - An accepted byte goes directly to BIT_LO; there is no second SETUP.
  - Waits indefinitely with CS low if no request arrives.
- HOLD:
  - Lasts CS_HOLD cycles.
  - Then spi_cs=1 with a frame_done pulse in the same cycle; go to IDLE.
  - tx_ready=0 throughout.
- tx_ready is 0 in SETUP, BIT_LO, BIT_HI and HOLD. tx_valid in those states is ignored; tx_data is not required to be held.
- spi_mosi holds its last value between bytes and returns to 0 in IDLE.
- Counters:
  - The divider counter is $clog2(max(CLK_DIV, CS_SETUP, CS_HOLD, GAP_MIN)) bits wide and wraps to 0 on each phase change.
  - The bit counter is 3 bits.
- rx_valid and frame_done never coincide: HOLD is at least 1 cycle.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined: the MISO sampler takes the internal spi_mosi instead of the spi_miso pin, so rx_data equals tx_data for every byte. The spi_miso port remains but is unused.
- Undefined: spi_miso is sampled as specified above.

Decomposition:
- Shared package `spi_pkg`:
  - state enum typedef (IDLE…HOLD);
  - SPI_MODE0 constant;
  - default timing constants CLK_DIV_DEF=5, CS_SETUP_DEF=5, CS_HOLD_DEF=5, GAP_MIN_DEF=10.
- One sub-module, `spi_sck_gen`: divider counter producing phase-end strobes and the rise strobe.
- FSM and shift registers stay in `spi_master_byte`.

Test Plan:
- Single byte 0xA5 with tx_last=1 and MISO driven by a model returning 0x3C:
  - CS low 1 cycle after accept;
  - 8 SCK pulses, each 5 low / 5 high cycles;
  - MOSI sequence 1,0,1,0,0,1,0,1;
  - rx_valid with rx_data=0x3C;
  - frame_done 5 cycles after the last SCK fall, and CS high in that cycle.
- Frame 0x01, 0x04, 0x00 (tx_last only on the last byte) driven into `spi_slave`:
  - CS stays low across all three bytes;
  - inter-byte gap ≥ 10 cycles;
  - exactly 3 rx_valid pulses and 1 frame_done;
  - `spi_slave` asserts spi_over.
- tx_valid held high during BIT_HI of byte 1: tx_ready=0 there, and the byte is accepted only after GAP_MIN cycles in GAP.
- rst pulsed during bit 4 of byte 0xFF:
  - outputs return to their reset values asynchronously;
  - no rx_valid or frame_done;
  - the next byte 0x81 completes normally.
- With SPI_MASTER_LOOPBACK_EN and spi_miso tied to 0: send 0x5A → rx_data=0x5A.
- CLK_DIV=2 with byte 0x80: SCK period is 4 cycles; rx_valid occurs 32 cycles after the first BIT_LO cycle.
